// File: rtl/pll_pkg.sv
// Shared definitions for the PLL loop filter: FSM states, datapath widths and
// default tuning constants.
package pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLAMP,
    ST_INTEG,
    ST_SUM,
    ST_OUT
  } pll_state_e;

  localparam int ACC_W = 40;
  localparam int ERR_W = 32;
  localparam int DAC_W = 16;

  localparam logic [DAC_W-1:0] DAC_MID_DEF     = 16'h8000;
  localparam int               ERR_LIMIT_DEF   = 4096;
  localparam int               INTEG_MAX_DEF   = 2**22;
  localparam int               LOCK_THRESH_DEF = 8;
  localparam int               LOCK_COUNT_DEF  = 16;
  localparam longint           DAC_MAX         = 65535;

  function automatic logic err_in_window(input logic signed [ERR_W-1:0] e,
                                         input int thresh);
    return (e <= thresh) && (e >= -thresh);
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Signed saturating clamp: limits d_i to [MIN_V, MAX_V] and resizes to OUT_W.
module sat_clamp #(
  parameter int     IN_W  = 40,
  parameter int     OUT_W = 16,
  parameter longint MIN_V = 0,
  parameter longint MAX_V = 65535
) (
  input  logic signed [IN_W-1:0]  d_i,
  output logic signed [OUT_W-1:0] q_o
);

  localparam logic signed [IN_W-1:0] LO = IN_W'(MIN_V);
  localparam logic signed [IN_W-1:0] HI = IN_W'(MAX_V);

  always_comb begin
    if (d_i > HI) begin
      q_o = OUT_W'(HI);
    end else if (d_i < LO) begin
      q_o = OUT_W'(LO);
    end else begin
      q_o = OUT_W'(d_i);
    end
  end

endmodule

// File: rtl/pll_loop_filter.sv
// PI loop filter steering a VCXO DAC from 1PPS phase/frequency error, with
// anti-windup integrator, lock detector and overrun flag.
module pll_loop_filter
  import pll_pkg::*;
#(
  parameter int               P_SHIFT     = 2,
  parameter int               I_SHIFT     = 6,
  parameter int               ERR_LIMIT   = ERR_LIMIT_DEF,
  parameter int               INTEG_MAX   = INTEG_MAX_DEF,
  parameter int               LOCK_THRESH = LOCK_THRESH_DEF,
  parameter int               LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter logic [DAC_W-1:0] DAC_MID     = DAC_MID_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_trig,
  input  logic signed [ERR_W-1:0] pdiff_1pps,
  input  logic signed [ERR_W-1:0] fdiff_1pps,
  input  logic                    pfd_status,
  input  logic                    gps_3dfix_d,
  input  logic                    loop_enable,
  input  logic                    dac_ready,
  output logic [DAC_W-1:0]        dac_data,
  output logic                    dac_valid,
  output logic signed [31:0]      integ_out,
  output logic                    pll_lock,
  output logic                    trig_overrun
);

  localparam int                       CNT_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]         LOCK_CNT_C = CNT_W'(LOCK_COUNT);
  localparam logic signed [ACC_W-1:0]  MID_EXT    = ACC_W'(DAC_MID);
  localparam logic signed [ACC_W-1:0]  SUM_MAX    = ACC_W'(DAC_MAX);

  pll_state_e state_q, state_d;

  logic                    qual;
  logic                    accept;
  logic signed [ERR_W-1:0] sel_q;
  logic                    pfd_q;
  logic signed [ERR_W-1:0] err_d, err_q;
  logic signed [ACC_W-1:0] err_ext;
  logic signed [ACC_W-1:0] integ_sum, integ_sat, integ_new_q;
  logic signed [ACC_W-1:0] integ_q, integ_d;
  logic signed [ACC_W-1:0] sum_raw;
  logic signed [DAC_W-1:0] dac_sat;
  logic [DAC_W-1:0]        dac_q, dac_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovr_q, ovr_d;
  logic                    err_pos, err_neg, hold_integ;

  assign qual   = loop_enable & gps_3dfix_d;
  assign accept = (state_q == ST_IDLE) && pll_trig && qual;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CLAMP;
      ST_CLAMP: state_d = ST_INTEG;
      ST_INTEG: state_d = ST_SUM;
      ST_SUM:   state_d = ST_OUT;
      ST_OUT:   if (dac_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  sat_clamp #(
    .IN_W (ERR_W),
    .OUT_W(ERR_W),
    .MIN_V(-longint'(ERR_LIMIT)),
    .MAX_V(longint'(ERR_LIMIT))
  ) u_err_sat (
    .d_i(sel_q),
    .q_o(err_d)
  );

  assign err_ext   = ACC_W'(err_q);
  assign integ_sum = integ_q + err_ext;

  sat_clamp #(
    .IN_W (ACC_W),
    .OUT_W(ACC_W),
    .MIN_V(-longint'(INTEG_MAX)),
    .MAX_V(longint'(INTEG_MAX))
  ) u_integ_sat (
    .d_i(integ_sum),
    .q_o(integ_sat)
  );

  assign sum_raw = MID_EXT + (err_ext >>> P_SHIFT) + (integ_new_q >>> I_SHIFT);

  sat_clamp #(
    .IN_W (ACC_W),
    .OUT_W(DAC_W),
    .MIN_V(0),
    .MAX_V(DAC_MAX)
  ) u_dac_sat (
    .d_i(sum_raw),
    .q_o(dac_sat)
  );

  sat_clamp #(
    .IN_W (ACC_W),
    .OUT_W(32),
    .MIN_V(-64'sd2147483648),
    .MAX_V(64'sd2147483647)
  ) u_out_sat (
    .d_i(integ_q),
    .q_o(integ_out)
  );

  // Anti-windup: freeze the integrator when the error would push the DAC
  // further into the rail it is already clipped against.
  assign err_neg    = err_q[ERR_W-1];
  assign err_pos    = !err_q[ERR_W-1] && (err_q != '0);
  assign hold_integ = ((sum_raw > SUM_MAX) && err_pos) ||
                      (sum_raw[ACC_W-1] && err_neg);

  always_comb begin
    dac_d   = dac_q;
    integ_d = integ_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    if (pll_trig && (state_q != ST_IDLE)) ovr_d = 1'b1;
    if (state_q == ST_SUM) begin
      dac_d = dac_sat;
      if (!hold_integ) integ_d = integ_new_q;
    end
    if (!qual) begin
      cnt_d = '0;
    end else if (state_q == ST_INTEG) begin
      if (pfd_q && err_in_window(err_q, LOCK_THRESH)) begin
        cnt_d = (cnt_q == LOCK_CNT_C) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dac_q   <= DAC_MID;
      integ_q <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      integ_q <= integ_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // Datapath registers: only meaningful while the FSM walks an update.
  always_ff @(posedge clk) begin
    if (accept) begin
      sel_q <= pfd_status ? pdiff_1pps : fdiff_1pps;
      pfd_q <= pfd_status;
    end
    if (state_q == ST_CLAMP) err_q <= err_d;
    if (state_q == ST_INTEG) integ_new_q <= integ_sat;
  end

  assign dac_data     = dac_q;
  assign dac_valid    = (state_q == ST_OUT);
  assign pll_lock     = (cnt_q == LOCK_CNT_C);
  assign trig_overrun = ovr_q;

endmodule

// File: doc/pll_loop_filter.md
PLL_LOOP_FILTER -- requirements
Module: pll_loop_filter

Interface
REQ-001 SHALL have parameter P_SHIFT, default 2: proportional term = err >>> P_SHIFT.
REQ-002 SHALL have parameter I_SHIFT, default 6: integral term = integ >>> I_SHIFT.
REQ-003 SHALL have parameter ERR_LIMIT, default 4096: symmetric clamp on the selected error, in clk cycles.
REQ-004 SHALL have parameter INTEG_MAX, default 2**22: symmetric integrator saturation bound.
REQ-005 SHALL have parameters LOCK_THRESH, default 8, and LOCK_COUNT, default 16: lock detector threshold and qualify count.
REQ-006 SHALL have parameter DAC_MID, default 16'h8000: VCXO DAC mid-scale and reset value.
REQ-007 clk  in  1  single 200 MHz clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 pll_trig  in  1  one-cycle strobe; pdiff_1pps/fdiff_1pps/pfd_status are valid this cycle.
REQ-010 pdiff_1pps  in  32  signed phase error, gps edge minus tsc edge; positive means tsc lags.
REQ-011 fdiff_1pps  in  32  signed frequency error, clk cycles per second.
REQ-012 pfd_status  in  1  1 = phase mode (use pdiff), 0 = frequency mode (use fdiff).
REQ-013 gps_3dfix_d  in  1  GPS fix qualifier.
REQ-014 loop_enable  in  1  software loop enable.
REQ-015 dac_ready  in  1  DAC SPI master accepts dac_data.
REQ-016 dac_data  out  16  VCXO control word.
REQ-017 dac_valid  out  1  dac_data valid; held until dac_ready.
REQ-018 integ_out  out  32  integrator readback, sign-extended or saturated to 32 bits.
REQ-019 pll_lock  out  1  loop locked.
REQ-020 trig_overrun  out  1  sticky flag: a pll_trig was dropped while busy.

Function
REQ-021 SHALL implement FSM IDLE→CLAMP→INTEG→SUM→OUT→IDLE, advancing one state per clk except in OUT.
REQ-022 In IDLE, SHALL accept pll_trig only when loop_enable=1 and gps_3dfix_d=1; otherwise it stays in IDLE and all outputs hold.
REQ-023 CLAMP SHALL register err = sel(pfd_status, pdiff_1pps, fdiff_1pps), clamped to ±ERR_LIMIT; the selection uses values sampled at the pll_trig cycle.
REQ-024 INTEG SHALL compute integ_new = integ + err, saturated to ±INTEG_MAX, in 40-bit signed arithmetic.
REQ-025 SUM SHALL compute sum = DAC_MID + (err >>> P_SHIFT) + (integ_new >>> I_SHIFT), using arithmetic shifts (floor) and a 40-bit signed intermediate.
REQ-026 SUM SHALL saturate the output to [0, 65535] and commit integ_new unless the output saturated and sign(err) drives further into that saturation (anti-windup).
REQ-027 dac_valid SHALL assert exactly 4 cycles after the accepted pll_trig and hold with stable dac_data until the cycle dac_ready=1; the FSM SHALL return to IDLE the next cycle.
REQ-028 pll_trig arriving in any state other than IDLE SHALL be dropped and SHALL set trig_overrun.
REQ-029 Lock counter: on each accepted update with pfd_status=1 and |err| ≤ LOCK_THRESH, SHALL increment, saturating at LOCK_COUNT; otherwise SHALL clear to 0.
REQ-030 pll_lock SHALL equal (count == LOCK_COUNT).
REQ-031 gps_3dfix_d=0 or loop_enable=0 SHALL clear pll_lock and the lock counter within 1 cycle; dac_data and integ SHALL hold (holdover).
REQ-032 An update in flight when the qualifiers drop SHALL complete normally.

Reset
REQ-033 rst SHALL take effect on the next edge, including mid-operation: FSM→IDLE, dac_data=DAC_MID, dac_valid=0, integ=0, lock count=0, pll_lock=0, trig_overrun=0.

Structure
REQ-034 The FSM state enum and default constants (DAC_MID, limits) SHALL reside in shared package pll_pkg.
REQ-035 Clamp/saturate SHALL be one parameterized sub-module, sat_clamp, instantiated for the error, integrator, and DAC paths.

Verification
REQ-036 Trig with pfd_status=1, pdiff=1000 after reset -> dac_valid at trig+4, dac_data=33033, integ_out=1000.
REQ-037 Next trig with pdiff=-1000 -> integ_out=0, dac_data=32518.
REQ-038 Trig with pdiff=100000 -> err clamped to 4096; integ_out increments by 4096.
REQ-039 Repeated pdiff=4096 with dac_ready=1 -> dac_data reaches 65535 and stays there; integ_out freezes once saturated.
REQ-040 pll_trig while dac_ready=0 holds dac_valid -> trig dropped, trig_overrun=1, dac_data unchanged.
REQ-041 16 trigs with pdiff=5 -> pll_lock=1 after the 16th; next pdiff=20 -> pll_lock=0; gps_3dfix_d=0 -> pll_lock=0 and dac_data holds.
